divmmc: RTL and testbench
=========================

# divmmc

Paging controller for the DivMMC overlay on the 48K memory map. It watches Z80 bus cycles and traps opcode fetches at the DivMMC entry and exit addresses. It holds the port 0xE3 control register. It drives the `divRom`, `divRam` and `divPage` selects consumed by the memory block, which sequences when the DivMMC ROM and RAM replace the Spectrum ROM at 0x0000–0x3FFF.

## Interface
- No parameters.
- `clock  in  1` — system clock; all state changes on its rising edge.
- `reset  in  1` — synchronous, active-high; clears all state.
- `enable  in  1` — automap enable; 0 disables all traps and forces automap off.
- `m1  in  1` — Z80 M1, active low.
- `mreq  in  1` — Z80 MREQ, active low.
- `iorq  in  1` — Z80 IORQ, active low.
- `rd  in  1` — Z80 RD, active low.
- `wr  in  1` — Z80 WR, active low.
- `a  in  16` — Z80 address bus.
- `di  in  8` — Z80 data bus, CPU to memory/IO.
- `divRom  out  1` — current access is served from DivMMC ROM.
- `divRam  out  1` — current access is served from DivMMC SRAM.
- `divPage  out  4` — DivMMC RAM page for 0x2000–0x3FFF.
- `mapped  out  1` — registered automap state, for status/debug.

## Operation
- Registers:
  - `conmem`: E3 bit 7.
  - `mapram`: E3 bit 6, sticky; a write can set it but never clear it; only reset clears it.
  - `page[3:0]`: E3 bits 3:0.
  - `automap`.
  - `pend`: 2-bit, one of NONE/ON/OFF.
  - `m1q`: m1 delayed one clock.
  - `iowq`: port-write strobe delayed one clock.
- Port write strobe `iow` = !iorq && !wr && m1 && a[7:0]==8'hE3.
  - Register update only on the first clock of the strobe (`iow && !iowq`). Longer strobes write once.
  - Bits 5:4 are ignored.
- Opcode fetch `fetch` = !m1 && !mreq && !rd.
- While `fetch` && `enable`:
  - a ∈ {0x0000, 0x0008, 0x0038, 0x0066, 0x04C6, 0x0562}: `pend` <= ON.
  - a ∈ 0x3D00–0x3DFF: `pend` <= ON, and the current access is mapped immediately (instant map, combinational `inst`).
  - a ∈ 0x1FF8–0x1FFF: `pend` <= OFF.
  - Any other address: `pend` unchanged.
- M1 end (`m1 && !m1q`):
  - pend=ON: `automap` <= 1.
  - pend=OFF: `automap` <= 0.
  - In all cases `pend` <= NONE.
- `enable`=0: `automap` <= 0 and `pend` <= NONE every clock. `conmem` and the E3 register still operate.
- Effective map `map` = `conmem` || `automap` || `inst`.
- Output decode:
  - `divRom` = `map` && a[15:13]==3'b000 && (`conmem` || !`mapram`).
  - `divRam` = `map` && ((a[15:13]==3'b000 && !`conmem` && `mapram`) || a[15:13]==3'b001).
  - `divPage` = `page`.
  - `mapped` = `automap`.
- `divRom` and `divRam` are never both 1.
- The memory block handles the page-3 write protect when mapram is active; this block does not gate writes.

## Timing
- Reset: `conmem`, `mapram`, `page`, `automap` = 0; `pend` = NONE; `m1q` = 1; `iowq` = 0. After reset, `divRom`, `divRam`, `mapped` = 0 and `divPage` = 0.
- `divRom` and `divRam` are combinational from `a` and the registered state. They are valid in the same cycle as the address, so the memory mux sees them for the access in progress.
- Delayed map/unmap:
  - The trapped fetch itself is served with the old mapping.
  - The new `automap` is visible from the clock after the edge that samples `m1` high, i.e. from the next machine cycle (the refresh portion excluded).
- Instant map: `divRom`/`divRam` assert in the same cycle `fetch` is seen at 0x3Dxx. `automap` then latches at M1 end.
- Port write: new `conmem`/`page`/`mapram` are visible the clock after the first strobe cycle.
- Simultaneous events:
  - Port write and M1 end in the same clock: both apply.
  - `reset` overrides everything.
  - `enable` falling while `pend`=ON: the trap is discarded.
- Reset mid-M1 clears `pend`. The following M1 end (with `m1q`=1 after reset) causes no edge.

## Test plan
- Reset, then read 0x0010 with an M1 fetch -> `divRom`=0, `divRam`=0, `divPage`=0, `mapped`=0.
- `enable`=1, M1 fetch at 0x0038, then M1 rises -> during the fetch `divRom`=0; from the next clock `mapped`=1, and a read at 0x0100 gives `divRom`=1.
- Mapped; M1 fetch at 0x1FFA -> `divRom`=1 during the fetch; after M1 rises `mapped`=0, and a read at 0x0000 gives `divRom`=0.
- Unmapped; M1 fetch at 0x3D2F -> `divRam`=1 in the fetch cycle (a[13]=1); `mapped`=1 after M1 ends. Repeat with `enable`=0 -> no map.
- OUT 0xE3 with 0x45, held 3 clocks -> `page`=5, `mapram`=1 (one update). Then with automap set, read 0x0000 -> `divRam`=1, `divRom`=0; read 0x2000 -> `divRam`=1, `divPage`=5. OUT 0xE3 with 0x00 -> `mapram` stays 1.
- OUT 0xE3 with 0x83 -> `conmem`=1: read 0x1000 -> `divRom`=1 with `mapped`=0; read 0x4000 -> both selects 0; assert `reset` -> all outputs 0 on the next clock.

Source files
------------

// File: rtl/divmmc.sv
// divmmc: DivMMC automap trap logic, port 0xE3 control register and ROM/RAM select decode
module divmmc (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        m1,
  input  logic        mreq,
  input  logic        iorq,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] a,
  input  logic [7:0]  di,
  output logic        divRom,
  output logic        divRam,
  output logic [3:0]  divPage,
  output logic        mapped
);
  localparam logic [1:0] NONE = 2'd0, ON = 2'd1, OFF = 2'd2;
  logic [1:0] pend, pend_n;
  logic [3:0] page, page_n;
  logic conmem, mapram, automap, m1q, iowq;
  logic conmem_n, mapram_n, automap_n;
  logic iow, wstb, trap, entry, inst, leave, m1end, map, low, unused_di;
  assign iow = !iorq && !wr && m1 && a[7:0] == 8'hE3;
  assign wstb = iow && !iowq;
  assign trap = !m1 && !mreq && !rd && enable;
  assign entry = trap && (a == 16'h0000 || a == 16'h0008 || a == 16'h0038 ||
                          a == 16'h0066 || a == 16'h04C6 || a == 16'h0562);
  assign inst = trap && a[15:8] == 8'h3D;
  assign leave = trap && a[15:3] == 13'h03FF;
  assign m1end = m1 && !m1q;
  assign unused_di = ^di[5:4];
  always_ff @(posedge clock) begin
    if (reset) begin
      conmem <= 1'b0;
      mapram <= 1'b0;
      page <= 4'd0;
      automap <= 1'b0;
      pend <= NONE;
      m1q <= 1'b1;
      iowq <= 1'b0;
    end else begin
      conmem <= conmem_n;
      mapram <= mapram_n;
      page <= page_n;
      automap <= automap_n;
      pend <= pend_n;
      m1q <= m1;
      iowq <= iow;
    end
  end
  // a trap arms pend during the fetch; automap only follows at the end of M1
  always_comb begin
    pend_n = !enable || m1end ? NONE : entry || inst ? ON : leave ? OFF : pend;
    automap_n = !enable ? 1'b0 : m1end && pend == ON ? 1'b1 : m1end && pend == OFF ? 1'b0 : automap;
    conmem_n = wstb ? di[7] : conmem;
    mapram_n = mapram || (wstb && di[6]);
    page_n = wstb ? di[3:0] : page;
  end
  always_comb begin
    map = conmem || automap || inst;
    low = a[15:13] == 3'b000;
    divRom = map && low && (conmem || !mapram);
    divRam = map && ((low && !conmem && mapram) || a[15:13] == 3'b001);
    divPage = page;
    mapped = automap;
  end
endmodule

// File: tb/tb_divmmc.sv
// tb_divmmc: bus-transaction bench for divmmc against a machine-cycle level model
module tb_divmmc;
  logic clock, reset, enable, m1, mreq, iorq, rd, wr;
  logic [15:0] a;
  logic [7:0] di;
  logic divRom, divRam, mapped;
  logic [3:0] divPage;
  int checks = 0, errors = 0;
  logic m_conmem, m_mapram, m_auto;
  logic [3:0] m_page;

  divmmc dut (
    .clock(clock), .reset(reset), .enable(enable), .m1(m1), .mreq(mreq),
    .iorq(iorq), .rd(rd), .wr(wr), .a(a), .di(di),
    .divRom(divRom), .divRam(divRam), .divPage(divPage), .mapped(mapped)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  function automatic int trap_kind(input logic [15:0] addr);
    if (addr == 16'h0000 || addr == 16'h0008 || addr == 16'h0038 || addr == 16'h0066 ||
        addr == 16'h04C6 || addr == 16'h0562 || (addr >= 16'h3D00 && addr <= 16'h3DFF))
      return 1;
    if (addr >= 16'h1FF8 && addr <= 16'h1FFF) return 2;
    return 0;
  endfunction

  function automatic logic is_inst(input logic [15:0] addr);
    return enable && addr >= 16'h3D00 && addr <= 16'h3DFF;
  endfunction

  // expected {divRom, divRam}: 8K bank 0 is ROM or RAM, bank 1 is RAM, above is untouched
  function automatic logic [1:0] exp_sel(input logic [15:0] addr, input logic inst);
    int bank;
    bank = addr / 16'h2000;
    if (!(m_conmem || m_auto || inst) || bank > 1) return 2'b00;
    if (bank == 1) return 2'b01;
    return (m_conmem || !m_mapram) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_conmem = 0; m_mapram = 0; m_auto = 0; m_page = 0;
  endtask

  task automatic idle();
    m1 = 1; mreq = 1; iorq = 1; rd = 1; wr = 1;
  endtask

  task automatic bus_fetch(input logic [15:0] addr, output logic [1:0] sel);
    int k;
    k = trap_kind(addr);
    a = addr; m1 = 0; mreq = 0; rd = 0;
    #1 sel = {divRom, divRam};
    @(posedge clock); @(negedge clock);
    idle();
    @(posedge clock); @(negedge clock);
    if (!enable) m_auto = 0;
    else if (k == 1) m_auto = 1;
    else if (k == 2) m_auto = 0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [1:0] sel);
    a = addr; mreq = 0; rd = 0;
    #1 sel = {divRom, divRam};
    @(posedge clock); @(negedge clock);
    idle();
  endtask

  // d0 is on the bus for the first strobe clock, drest for the remaining ones
  task automatic bus_out(input logic [7:0] d0, input logic [7:0] drest, input int n);
    a = {8'($urandom), 8'hE3}; di = d0; iorq = 0; wr = 0;
    @(posedge clock); @(negedge clock);
    di = drest;
    repeat (n - 1) begin @(posedge clock); @(negedge clock); end
    idle();
    @(posedge clock); @(negedge clock);
    m_conmem = d0[7]; m_mapram = m_mapram | d0[6]; m_page = d0[3:0];
  endtask

  task automatic set_enable(input logic v);
    enable = v;
    if (!v) m_auto = 0;
    @(posedge clock); @(negedge clock);
  endtask

  task automatic test_reset();
    logic [1:0] s;
    reset = 1; enable = 1; di = 8'hFF; a = 16'h0038; idle();
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 0; model_reset();
    checks++; if (mapped !== 0) begin errors++; $display("FAIL reset_mapped got %b exp 0", mapped); end
    checks++; if (divPage !== 0) begin errors++; $display("FAIL reset_page got %h exp 0", divPage); end
    bus_fetch(16'h0010, s);
    checks++; if (s !== 2'b00) begin errors++; $display("FAIL reset_fetch_sel got %b exp 00", s); end
    checks++; if (mapped !== 0) begin errors++; $display("FAIL reset_fetch_mapped got %b exp 0", mapped); end
  endtask

  task automatic test_entry();
    logic [1:0] s;
    bus_fetch(16'h0038, s);
    checks++; if (s !== 2'b00) begin errors++; $display("FAIL entry_fetch_sel got %b exp 00", s); end
    checks++; if (mapped !== 1) begin errors++; $display("FAIL entry_mapped got %b exp 1", mapped); end
    bus_read(16'h0100, s);
    checks++; if (s !== 2'b10) begin errors++; $display("FAIL entry_read_sel got %b exp 10", s); end
  endtask

  task automatic test_exit();
    logic [1:0] s;
    bus_fetch(16'h1FFA, s);
    checks++; if (s !== 2'b10) begin errors++; $display("FAIL exit_fetch_sel got %b exp 10", s); end
    checks++; if (mapped !== 0) begin errors++; $display("FAIL exit_mapped got %b exp 0", mapped); end
    bus_read(16'h0000, s);
    checks++; if (s !== 2'b00) begin errors++; $display("FAIL exit_read_sel got %b exp 00", s); end
  endtask

  task automatic test_instant();
    logic [1:0] s;
    bus_fetch(16'h3D2F, s);
    checks++; if (s !== 2'b01) begin errors++; $display("FAIL inst_fetch_sel got %b exp 01", s); end
    checks++; if (mapped !== 1) begin errors++; $display("FAIL inst_mapped got %b exp 1", mapped); end
    bus_fetch(16'h1FF8, s);
    checks++; if (s !== 2'b10) begin errors++; $display("FAIL inst_exit_sel got %b exp 10", s); end
    set_enable(0);
    bus_fetch(16'h3D2F, s);
    checks++; if (s !== 2'b00) begin errors++; $display("FAIL inst_dis_sel got %b exp 00", s); end
    checks++; if (mapped !== 0) begin errors++; $display("FAIL inst_dis_mapped got %b exp 0", mapped); end
    set_enable(1);
  endtask

  task automatic test_e3();
    logic [1:0] s;
    bus_out(8'h45, 8'h0A, 3);
    checks++; if (divPage !== 4'h5) begin errors++; $display("FAIL e3_page got %h exp 5", divPage); end
    bus_fetch(16'h0000, s);
    checks++; if (s !== 2'b00) begin errors++; $display("FAIL e3_fetch_sel got %b exp 00", s); end
    bus_read(16'h0000, s);
    checks++; if (s !== 2'b01) begin errors++; $display("FAIL e3_mapram_sel got %b exp 01", s); end
    bus_read(16'h2000, s);
    checks++; if (s !== 2'b01) begin errors++; $display("FAIL e3_bank1_sel got %b exp 01", s); end
    bus_out(8'h00, 8'h00, 1);
    bus_read(16'h0000, s);
    checks++; if (s !== 2'b01) begin errors++; $display("FAIL e3_sticky_sel got %b exp 01", s); end
    checks++; if (divPage !== 4'h0) begin errors++; $display("FAIL e3_page0 got %h exp 0", divPage); end
  endtask

  task automatic test_conmem();
    logic [1:0] s;
    bus_fetch(16'h1FF8, s);
    checks++; if (s !== 2'b01) begin errors++; $display("FAIL con_exit_sel got %b exp 01", s); end
    bus_out(8'h83, 8'h83, 1);
    bus_read(16'h1000, s);
    checks++; if (s !== 2'b10) begin errors++; $display("FAIL con_rom_sel got %b exp 10", s); end
    checks++; if (mapped !== 0) begin errors++; $display("FAIL con_mapped got %b exp 0", mapped); end
    bus_read(16'h4000, s);
    checks++; if (s !== 2'b00) begin errors++; $display("FAIL con_high_sel got %b exp 00", s); end
    a = 16'h1000; mreq = 0; rd = 0; reset = 1;
    @(posedge clock); @(negedge clock);
    checks++; if ({divRom, divRam, mapped, divPage} !== 7'd0)
      begin errors++; $display("FAIL con_reset got %b%b%b %h exp all 0", divRom, divRam, mapped, divPage); end
    reset = 0; idle(); model_reset();
  endtask

  task automatic test_simultaneous();
    a = 16'h0038; m1 = 0; mreq = 0; rd = 0;
    @(posedge clock); @(negedge clock);
    idle(); a = 16'h12E3; di = 8'h07; iorq = 0; wr = 0;
    @(posedge clock); @(negedge clock);
    idle();
    checks++; if (mapped !== 1) begin errors++; $display("FAIL simul_mapped got %b exp 1", mapped); end
    checks++; if (divPage !== 4'h7) begin errors++; $display("FAIL simul_page got %h exp 7", divPage); end
    @(posedge clock); @(negedge clock);
    m_auto = 1; m_conmem = 0; m_page = 7;
  endtask

  task automatic test_reset_mid_m1();
    a = 16'h0066; m1 = 0; mreq = 0; rd = 0;
    @(posedge clock); @(negedge clock);
    reset = 1;
    @(posedge clock); @(negedge clock);
    reset = 0; idle();
    @(posedge clock); @(negedge clock);
    checks++; if (mapped !== 0) begin errors++; $display("FAIL midreset_mapped got %b exp 0", mapped); end
    model_reset();
  endtask

  task automatic test_enable_drop();
    a = 16'h0066; m1 = 0; mreq = 0; rd = 0;
    @(posedge clock); @(negedge clock);
    enable = 0;
    @(posedge clock); @(negedge clock);
    enable = 1; idle();
    @(posedge clock); @(negedge clock);
    checks++; if (mapped !== 0) begin errors++; $display("FAIL endrop_mapped got %b exp 0", mapped); end
    m_auto = 0;
  endtask

  task automatic test_random();
    logic [1:0] s, e;
    logic [15:0] addr;
    logic [15:0] traps [8] = '{16'h0000, 16'h0008, 16'h0038, 16'h0066, 16'h04C6, 16'h0562, 16'h3D00, 16'h1FF8};
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        addr = $urandom_range(0, 2) == 0 ? 16'($urandom) : traps[$urandom_range(0, 7)];
        if (addr == 16'h3D00) addr = addr + 16'($urandom_range(0, 255));
        if (addr == 16'h1FF8) addr = addr + 16'($urandom_range(0, 7));
        e = exp_sel(addr, is_inst(addr));
        bus_fetch(addr, s);
        checks++; if (s !== e) begin errors++; $display("FAIL rnd_fetch_sel a=%h got %b exp %b", addr, s, e); end
        checks++; if (mapped !== m_auto) begin errors++; $display("FAIL rnd_mapped a=%h got %b exp %b", addr, mapped, m_auto); end
      end else if (r <= 6) begin
        addr = 16'($urandom_range(0, 16'h5FFF));
        e = exp_sel(addr, 1'b0);
        bus_read(addr, s);
        checks++; if (s !== e) begin errors++; $display("FAIL rnd_read_sel a=%h got %b exp %b", addr, s, e); end
      end else if (r <= 8) begin
        bus_out(8'($urandom), 8'($urandom), $urandom_range(1, 3));
        checks++; if (divPage !== m_page) begin errors++; $display("FAIL rnd_page got %h exp %h", divPage, m_page); end
      end else begin
        set_enable($urandom_range(0, 4) != 0);
        checks++; if (mapped !== m_auto) begin errors++; $display("FAIL rnd_en_mapped got %b exp %b", mapped, m_auto); end
      end
    end
  endtask

  initial begin
    reset = 1; enable = 0; a = 0; di = 0; idle(); model_reset();
    @(negedge clock);
    test_reset();
    test_entry();
    test_exit();
    test_instant();
    test_e3();
    test_conmem();
    test_simultaneous();
    test_reset_mid_m1();
    test_enable_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
